ysyx_23060136_wb_commit: RTL and testbench
==========================================

# ysyx_23060136_wb_commit

Writeback stage that consumes the MEM/WB pipeline register outputs. Drives GPR and CSR write ports, retires committed instructions into a small commit FIFO drained by the difftest/trace port, and runs the halt sequence. Generates `FORWARD_stallWB`, the backpressure that freezes the MEM/WB register when retirement cannot proceed. Sits between the MEM/WB register and the register files / simulation environment.

## Interface
- `COMMIT_DEPTH`, 4: commit FIFO entries; power of two, ≥2.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-low.
- `WB_i_commit` input 1: slot holds a real instruction.
- `WB_i_pc` input BITS_W, `WB_i_inst` input INST_W: retiring instruction.
- `WB_i_ALU_ALUout`, `WB_i_ALU_CSR_out`, `WB_i_rdata` input BITS_W: result candidates.
- `WB_i_write_gpr`, `WB_i_write_csr_1`, `WB_i_write_csr_2`, `WB_i_mem_to_reg` input 1: write controls.
- `WB_i_rd` input GPR_W; `WB_i_csr_rd_1`, `WB_i_csr_rd_2` input CSR_W: destinations.
- `WB_i_system_halt` input 1: instruction is the halt (ebreak).
- `FORWARD_stallWB` output 1: hold MEM/WB register.
- `WB_o_gpr_we` output 1; `WB_o_gpr_waddr` output GPR_W; `WB_o_gpr_wdata` output BITS_W.
- `WB_o_csr_we_1` output 1; `WB_o_csr_waddr_1` output CSR_W; `WB_o_csr_wdata_1` output BITS_W.
- `WB_o_csr_we_2` output 1; `WB_o_csr_waddr_2` output CSR_W; `WB_o_csr_wdata_2` output BITS_W.
- `WB_o_commit_valid` output 1; `WB_o_commit_ready` input 1; `WB_o_commit_pc` output BITS_W; `WB_o_commit_inst` output INST_W: retirement stream.
- `WB_o_retire_cnt` output 64: accepted-commit count.
- `WB_o_halted` output 1: halt sequence complete.

## Operation
- accept = `WB_i_commit & ~FORWARD_stallWB`.
- `FORWARD_stallWB` = (state==RUN & WB_i_commit & fifo_full) | state!=RUN; full is registered occupancy, so a pop in the same cycle does not unblock a push.
- GPR: we = `WB_i_write_gpr` & accept & rd≠0; wdata = mem_to_reg ? rdata : ALUout; waddr = rd.
- CSR1: we = write_csr_1 & accept; wdata = ALU_CSR_out. CSR2: we = write_csr_2 & accept; wdata = ALU_ALUout.
- Stalled or non-commit slots produce no writes and no push: each instruction has exactly one effect despite being held multiple cycles.
- On accept: push {pc, inst}; retire_cnt += 1 (wraps at 2^64).
- Pop when commit_valid & commit_ready; commit_valid = ~empty; head pc/inst valid while commit_valid, stable until popped.
- FSM (typedef wb_state_t): RUN → DRAIN on accept with `WB_i_system_halt`=1 (halt instruction is pushed and its writes performed); DRAIN → HALTED when FIFO empty; HALTED terminal until reset. `WB_o_halted` = state==HALTED.
- Halt with `WB_i_commit`=0 ignored.

## Timing
- Reset (async, any time including mid-drain): state RUN, FIFO empty, retire_cnt 0, commit_valid 0, halted 0; combinational outputs follow inputs with empty FIFO.
- Write ports combinational, same cycle as accept; register files capture at next edge.
- Commit latency: accepted at edge N → commit_valid high after edge N (1 cycle).
- Full: stall asserted same cycle combinationally; lifts the cycle after occupancy drops below COMMIT_DEPTH.
- Halted asserts the cycle after the last entry pops.

## Structure
- Shared package: `wb_state_t` enum {WB_RUN, WB_DRAIN, WB_HALTED}; `commit_entry_t` struct {pc, inst}.
- Sub-module `ysyx_23060136_commit_fifo`: synchronous FIFO, parameterized depth/entry type, ptr+1-bit wrap full/empty, async active-low reset.

## Test plan
- Reset, ready=1, 3 committed ALU instrs rd=5, ALUout=0x10/0x20/0x30 → three gpr_we pulses with those values, commit stream pc order preserved 1 cycle later, retire_cnt=3.
- mem_to_reg=1, rdata=0xDEAD, rd=0 → gpr_we=0; rd=7 → wdata=0xDEAD.
- ready=0, 6 back-to-back commits, DEPTH=4 → stallWB high on 5th, exactly 4 gpr_we pulses; release ready → remaining 2 retire once each, retire_cnt=6.
- Halt instr with 2 entries queued, ready=1 → DRAIN, stallWB=1, halted asserted the cycle after 3rd pop, subsequent commits ignored.
- Assert rst low mid-DRAIN with full FIFO → commit_valid=0, halted=0, retire_cnt=0 immediately; normal retire after release.

Source files
------------

// File: rtl/ysyx_23060136_wb_commit_pkg.sv
// Shared types and widths for the writeback/commit stage and its commit FIFO.
package ysyx_23060136_wb_commit_pkg;

  localparam int BITS_W = 32;
  localparam int INST_W = 32;
  localparam int GPR_W  = 5;
  localparam int CSR_W  = 12;

  // Retirement state: running, draining after the halt instruction, halted.
  typedef enum logic [1:0] {
    WB_RUN    = 2'd0,
    WB_DRAIN  = 2'd1,
    WB_HALTED = 2'd2
  } wb_state_t;

  // One retired instruction as seen by the difftest/trace port.
  typedef struct packed {
    logic [BITS_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } commit_entry_t;

  // GPR result select: loads take memory data, everything else the ALU result.
  function automatic logic [BITS_W-1:0] wb_gpr_data(
    input logic              mem_to_reg,
    input logic [BITS_W-1:0] rdata,
    input logic [BITS_W-1:0] alu_out
  );
    logic [BITS_W-1:0] res;
    if (mem_to_reg) begin
      res = rdata;
    end else begin
      res = alu_out;
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_23060136_commit_fifo.sv
// Synchronous FIFO holding retired instructions until the trace port takes them.
// Pointers carry one extra wrap bit so full and empty come straight from flops.
module ysyx_23060136_commit_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [63:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  entry_t      mem_q [DEPTH];
  entry_t      mem_d [DEPTH];
  logic        do_push_s;
  logic        do_pop_s;

  // Status flags, guarded push/pop, pointer advance and storage update.
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count     = wr_ptr_q - rd_ptr_q;
    head      = mem_q[rd_ptr_q[AW-1:0]];
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer and storage registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/ysyx_23060136_wb_commit.sv
// Writeback stage: register-file write ports, commit FIFO feeding the
// difftest/trace port, retire counter and the halt/drain sequence.
module ysyx_23060136_wb_commit
  import ysyx_23060136_wb_commit_pkg::*;
#(
  parameter int COMMIT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_i_commit,
  input  logic [BITS_W-1:0] WB_i_pc,
  input  logic [INST_W-1:0] WB_i_inst,
  input  logic [BITS_W-1:0] WB_i_ALU_ALUout,
  input  logic [BITS_W-1:0] WB_i_ALU_CSR_out,
  input  logic [BITS_W-1:0] WB_i_rdata,
  input  logic              WB_i_write_gpr,
  input  logic              WB_i_write_csr_1,
  input  logic              WB_i_write_csr_2,
  input  logic              WB_i_mem_to_reg,
  input  logic [GPR_W-1:0]  WB_i_rd,
  input  logic [CSR_W-1:0]  WB_i_csr_rd_1,
  input  logic [CSR_W-1:0]  WB_i_csr_rd_2,
  input  logic              WB_i_system_halt,
  output logic              FORWARD_stallWB,
  output logic              WB_o_gpr_we,
  output logic [GPR_W-1:0]  WB_o_gpr_waddr,
  output logic [BITS_W-1:0] WB_o_gpr_wdata,
  output logic              WB_o_csr_we_1,
  output logic [CSR_W-1:0]  WB_o_csr_waddr_1,
  output logic [BITS_W-1:0] WB_o_csr_wdata_1,
  output logic              WB_o_csr_we_2,
  output logic [CSR_W-1:0]  WB_o_csr_waddr_2,
  output logic [BITS_W-1:0] WB_o_csr_wdata_2,
  output logic              WB_o_commit_valid,
  input  logic              WB_o_commit_ready,
  output logic [BITS_W-1:0] WB_o_commit_pc,
  output logic [INST_W-1:0] WB_o_commit_inst,
  output logic [63:0]       WB_o_retire_cnt,
  output logic              WB_o_halted
);

  localparam int               CW      = $clog2(COMMIT_DEPTH) + 1;
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);

  wb_state_t      state_q, state_d;
  logic [63:0]    retire_cnt_q, retire_cnt_d;

  logic           accept_s;
  logic           fifo_push_s;
  logic           fifo_pop_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic [CW-1:0]  fifo_count_s;
  logic           drain_done_s;
  commit_entry_t  push_entry_s;
  commit_entry_t  head_entry_s;

  ysyx_23060136_commit_fifo #(
    .DEPTH   (COMMIT_DEPTH),
    .entry_t (commit_entry_t)
  ) u_commit_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (fifo_push_s),
    .push_data (push_entry_s),
    .pop       (fifo_pop_s),
    .head      (head_entry_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Backpressure and acceptance: a held slot is accepted exactly once.
  // Full is registered, so a pop in this cycle does not free a push slot yet.
  always_comb begin
    FORWARD_stallWB = ((state_q == WB_RUN) & WB_i_commit & fifo_full_s) |
                      (state_q != WB_RUN);
    accept_s        = WB_i_commit & ~FORWARD_stallWB;
    fifo_push_s     = accept_s;
    push_entry_s.pc   = WB_i_pc;
    push_entry_s.inst = WB_i_inst;
  end

  // Register-file write ports, valid only in the cycle of acceptance.
  always_comb begin
    WB_o_gpr_we      = WB_i_write_gpr & accept_s & (WB_i_rd != {GPR_W{1'b0}});
    WB_o_gpr_waddr   = WB_i_rd;
    WB_o_gpr_wdata   = wb_gpr_data(WB_i_mem_to_reg, WB_i_rdata, WB_i_ALU_ALUout);
    WB_o_csr_we_1    = WB_i_write_csr_1 & accept_s;
    WB_o_csr_waddr_1 = WB_i_csr_rd_1;
    WB_o_csr_wdata_1 = WB_i_ALU_CSR_out;
    WB_o_csr_we_2    = WB_i_write_csr_2 & accept_s;
    WB_o_csr_waddr_2 = WB_i_csr_rd_2;
    WB_o_csr_wdata_2 = WB_i_ALU_ALUout;
  end

  // Trace-port handshake straight off the FIFO head.
  always_comb begin
    WB_o_commit_valid = ~fifo_empty_s;
    WB_o_commit_pc    = head_entry_s.pc;
    WB_o_commit_inst  = head_entry_s.inst;
    fifo_pop_s        = WB_o_commit_valid & WB_o_commit_ready;
  end

  // Retire counter advances once per accepted instruction, wrapping at 2^64.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (accept_s) begin
      retire_cnt_d = retire_cnt_q + 64'd1;
    end else begin
      retire_cnt_d = retire_cnt_q;
    end
  end

  // Halt sequence: after the halt retires, drain the FIFO, then stop for good.
  // Draining completes when the FIFO is empty now or its last entry pops now.
  always_comb begin
    state_d      = state_q;
    drain_done_s = fifo_empty_s | (fifo_pop_s & (fifo_count_s == CNT_ONE));
    case (state_q)
      WB_RUN: begin
        if (accept_s & WB_i_system_halt) begin
          state_d = WB_DRAIN;
        end else begin
          state_d = WB_RUN;
        end
      end
      WB_DRAIN: begin
        if (drain_done_s) begin
          state_d = WB_HALTED;
        end else begin
          state_d = WB_DRAIN;
        end
      end
      WB_HALTED: begin
        state_d = WB_HALTED;
      end
      default: begin
        state_d = WB_RUN;
      end
    endcase
  end

  // State and retire-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= WB_RUN;
      retire_cnt_q <= 64'd0;
    end else begin
      state_q      <= state_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Status outputs taken directly from flops.
  always_comb begin
    WB_o_retire_cnt = retire_cnt_q;
    WB_o_halted     = (state_q == WB_HALTED);
  end

endmodule

// File: tb/tb_ysyx_23060136_wb_commit.sv
// Directed bench for the writeback/commit stage.
module tb_ysyx_23060136_wb_commit;

  logic        clk;
  logic        rst;
  logic        WB_i_commit;
  logic [31:0] WB_i_pc;
  logic [31:0] WB_i_inst;
  logic [31:0] WB_i_ALU_ALUout;
  logic [31:0] WB_i_ALU_CSR_out;
  logic [31:0] WB_i_rdata;
  logic        WB_i_write_gpr;
  logic        WB_i_write_csr_1;
  logic        WB_i_write_csr_2;
  logic        WB_i_mem_to_reg;
  logic [4:0]  WB_i_rd;
  logic [11:0] WB_i_csr_rd_1;
  logic [11:0] WB_i_csr_rd_2;
  logic        WB_i_system_halt;
  logic        FORWARD_stallWB;
  logic        WB_o_gpr_we;
  logic [4:0]  WB_o_gpr_waddr;
  logic [31:0] WB_o_gpr_wdata;
  logic        WB_o_csr_we_1;
  logic [11:0] WB_o_csr_waddr_1;
  logic [31:0] WB_o_csr_wdata_1;
  logic        WB_o_csr_we_2;
  logic [11:0] WB_o_csr_waddr_2;
  logic [31:0] WB_o_csr_wdata_2;
  logic        WB_o_commit_valid;
  logic        WB_o_commit_ready;
  logic [31:0] WB_o_commit_pc;
  logic [31:0] WB_o_commit_inst;
  logic [63:0] WB_o_retire_cnt;
  logic        WB_o_halted;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          gpr_pulses;
  int          k;
  logic [31:0] exp_q [$];
  logic [31:0] exp_pc;

  ysyx_23060136_wb_commit #(.COMMIT_DEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .WB_i_commit       (WB_i_commit),
    .WB_i_pc           (WB_i_pc),
    .WB_i_inst         (WB_i_inst),
    .WB_i_ALU_ALUout   (WB_i_ALU_ALUout),
    .WB_i_ALU_CSR_out  (WB_i_ALU_CSR_out),
    .WB_i_rdata        (WB_i_rdata),
    .WB_i_write_gpr    (WB_i_write_gpr),
    .WB_i_write_csr_1  (WB_i_write_csr_1),
    .WB_i_write_csr_2  (WB_i_write_csr_2),
    .WB_i_mem_to_reg   (WB_i_mem_to_reg),
    .WB_i_rd           (WB_i_rd),
    .WB_i_csr_rd_1     (WB_i_csr_rd_1),
    .WB_i_csr_rd_2     (WB_i_csr_rd_2),
    .WB_i_system_halt  (WB_i_system_halt),
    .FORWARD_stallWB   (FORWARD_stallWB),
    .WB_o_gpr_we       (WB_o_gpr_we),
    .WB_o_gpr_waddr    (WB_o_gpr_waddr),
    .WB_o_gpr_wdata    (WB_o_gpr_wdata),
    .WB_o_csr_we_1     (WB_o_csr_we_1),
    .WB_o_csr_waddr_1  (WB_o_csr_waddr_1),
    .WB_o_csr_wdata_1  (WB_o_csr_wdata_1),
    .WB_o_csr_we_2     (WB_o_csr_we_2),
    .WB_o_csr_waddr_2  (WB_o_csr_waddr_2),
    .WB_o_csr_wdata_2  (WB_o_csr_wdata_2),
    .WB_o_commit_valid (WB_o_commit_valid),
    .WB_o_commit_ready (WB_o_commit_ready),
    .WB_o_commit_pc    (WB_o_commit_pc),
    .WB_o_commit_inst  (WB_o_commit_inst),
    .WB_o_retire_cnt   (WB_o_retire_cnt),
    .WB_o_halted       (WB_o_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WB_i_commit      = 1'b0;
    WB_i_write_gpr   = 1'b0;
    WB_i_write_csr_1 = 1'b0;
    WB_i_write_csr_2 = 1'b0;
    WB_i_mem_to_reg  = 1'b0;
    WB_i_system_halt = 1'b0;
  endtask

  // Present one committed instruction; inst encodes the pc so the stream check covers it.
  task automatic drive(input logic [31:0] pc, input logic [31:0] alu,
                       input logic [4:0] rd, input logic halt);
    WB_i_commit      = 1'b1;
    WB_i_pc          = pc;
    WB_i_inst        = {pc[15:0], 16'h0013};
    WB_i_ALU_ALUout  = alu;
    WB_i_rd          = rd;
    WB_i_write_gpr   = 1'b1;
    WB_i_mem_to_reg  = 1'b0;
    WB_i_write_csr_1 = 1'b0;
    WB_i_write_csr_2 = 1'b0;
    WB_i_system_halt = halt;
  endtask

  // Stream monitor: every pop must deliver the next expected pc/inst in order.
  always @(negedge clk) begin
    if (rst && WB_o_commit_valid && WB_o_commit_ready) begin
      if (exp_q.size() > 0) begin
        exp_pc = exp_q.pop_front();
        chk("stream_pc", 64'(WB_o_commit_pc), 64'(exp_pc));
        chk("stream_inst", 64'(WB_o_commit_inst), {32'h0, exp_pc[15:0], 16'h0013});
      end else begin
        chk("stream_unexpected_pop", 64'(WB_o_commit_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    WB_i_pc = 32'h0; WB_i_inst = 32'h0; WB_i_ALU_ALUout = 32'h0;
    WB_i_ALU_CSR_out = 32'h0; WB_i_rdata = 32'h0; WB_i_rd = 5'd0;
    WB_i_csr_rd_1 = 12'h0; WB_i_csr_rd_2 = 12'h0;
    WB_o_commit_ready = 1'b1;
    idle();
    #2;
    chk("rst_valid", 64'(WB_o_commit_valid), 64'd0);
    chk("rst_halted", 64'(WB_o_halted), 64'd0);
    chk("rst_cnt", WB_o_retire_cnt, 64'd0);
    chk("rst_stall", 64'(FORWARD_stallWB), 64'd0);
    step();
    rst = 1'b1;
    step();

    // Three ALU instructions to rd=5, trace port always ready.
    drive(32'h100, 32'h10, 5'd5, 1'b0); exp_q.push_back(32'h100); #1;
    chk("t1_we0", 64'(WB_o_gpr_we), 64'd1);
    chk("t1_waddr0", 64'(WB_o_gpr_waddr), 64'd5);
    chk("t1_wdata0", 64'(WB_o_gpr_wdata), 64'h10);
    chk("t1_stall0", 64'(FORWARD_stallWB), 64'd0);
    chk("t1_valid_before", 64'(WB_o_commit_valid), 64'd0);
    step();
    drive(32'h104, 32'h20, 5'd5, 1'b0); exp_q.push_back(32'h104); #1;
    chk("t1_wdata1", 64'(WB_o_gpr_wdata), 64'h20);
    chk("t1_valid_lat1", 64'(WB_o_commit_valid), 64'd1);
    chk("t1_head0", 64'(WB_o_commit_pc), 64'h100);
    step();
    drive(32'h108, 32'h30, 5'd5, 1'b0); exp_q.push_back(32'h108); #1;
    chk("t1_wdata2", 64'(WB_o_gpr_wdata), 64'h30);
    chk("t1_head1", 64'(WB_o_commit_pc), 64'h104);
    step();
    idle(); #1;
    chk("t1_head2", 64'(WB_o_commit_pc), 64'h108);
    step(); #1;
    chk("t1_empty", 64'(WB_o_commit_valid), 64'd0);
    chk("t1_cnt", WB_o_retire_cnt, 64'd3);

    // Load results: rd=0 never writes, rd=7 takes memory data; CSR ports alongside.
    drive(32'h10C, 32'h1234, 5'd0, 1'b0); exp_q.push_back(32'h10C);
    WB_i_mem_to_reg = 1'b1; WB_i_rdata = 32'hDEAD; #1;
    chk("t2_rd0_we", 64'(WB_o_gpr_we), 64'd0);
    chk("t2_csr1_off", 64'(WB_o_csr_we_1), 64'd0);
    step();
    drive(32'h110, 32'h55, 5'd7, 1'b0); exp_q.push_back(32'h110);
    WB_i_mem_to_reg = 1'b1; WB_i_rdata = 32'hDEAD;
    WB_i_write_csr_1 = 1'b1; WB_i_csr_rd_1 = 12'h300; WB_i_ALU_CSR_out = 32'hAAAA;
    WB_i_write_csr_2 = 1'b1; WB_i_csr_rd_2 = 12'h341; #1;
    chk("t2_we", 64'(WB_o_gpr_we), 64'd1);
    chk("t2_waddr", 64'(WB_o_gpr_waddr), 64'd7);
    chk("t2_wdata", 64'(WB_o_gpr_wdata), 64'hDEAD);
    chk("t2_csr1_we", 64'(WB_o_csr_we_1), 64'd1);
    chk("t2_csr1_addr", 64'(WB_o_csr_waddr_1), 64'h300);
    chk("t2_csr1_data", 64'(WB_o_csr_wdata_1), 64'hAAAA);
    chk("t2_csr2_we", 64'(WB_o_csr_we_2), 64'd1);
    chk("t2_csr2_addr", 64'(WB_o_csr_waddr_2), 64'h341);
    chk("t2_csr2_data", 64'(WB_o_csr_wdata_2), 64'h55);
    step();
    idle();
    step(); #1;
    chk("t2_empty", 64'(WB_o_commit_valid), 64'd0);
    chk("t2_cnt", WB_o_retire_cnt, 64'd5);

    // Six back-to-back commits with the trace port stalled: the 5th sees full.
    WB_o_commit_ready = 1'b0;
    gpr_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      drive(32'h200 + 32'(4 * i), 32'(i + 1), 5'd3, 1'b0); exp_q.push_back(32'h200 + 32'(4 * i)); #1;
      chk("t3_nostall", 64'(FORWARD_stallWB), 64'd0);
      if (WB_o_gpr_we) gpr_pulses++;
      step();
    end
    drive(32'h210, 32'h5, 5'd3, 1'b0); #1;
    chk("t3_stall5", 64'(FORWARD_stallWB), 64'd1);
    chk("t3_we_stalled", 64'(WB_o_gpr_we), 64'd0);
    if (WB_o_gpr_we) gpr_pulses++;
    step();
    chk("t3_stall_hold", 64'(FORWARD_stallWB), 64'd1);
    if (WB_o_gpr_we) gpr_pulses++;
    step();
    WB_o_commit_ready = 1'b1; #1;
    chk("t3_stall_pop_same_cycle", 64'(FORWARD_stallWB), 64'd1);
    if (WB_o_gpr_we) gpr_pulses++;
    chk("t3_pulses_while_full", 64'(gpr_pulses), 64'd4);
    step(); #1;
    chk("t3_stall_lifted", 64'(FORWARD_stallWB), 64'd0);
    chk("t3_wdata5", 64'(WB_o_gpr_wdata), 64'h5);
    exp_q.push_back(32'h210);
    if (WB_o_gpr_we) gpr_pulses++;
    step();
    drive(32'h214, 32'h6, 5'd3, 1'b0); exp_q.push_back(32'h214); #1;
    chk("t3_nostall6", 64'(FORWARD_stallWB), 64'd0);
    if (WB_o_gpr_we) gpr_pulses++;
    step();
    idle();
    k = 0;
    while (WB_o_commit_valid === 1'b1 && k < 10) begin
      step();
      k++;
    end
    chk("t3_drained", 64'(WB_o_commit_valid), 64'd0);
    chk("t3_pulses", 64'(gpr_pulses), 64'd6);
    chk("t3_cnt", WB_o_retire_cnt, 64'd11);
    chk("t3_stream_done", 64'(exp_q.size()), 64'd0);

    // Halt behind two queued entries, then drain with the trace port ready.
    WB_o_commit_ready = 1'b0;
    drive(32'h300, 32'h1, 5'd2, 1'b0); exp_q.push_back(32'h300); step();
    drive(32'h304, 32'h2, 5'd2, 1'b0); exp_q.push_back(32'h304); step();
    drive(32'h308, 32'h77, 5'd1, 1'b1); exp_q.push_back(32'h308); #1;
    chk("t4_halt_accept", 64'(FORWARD_stallWB), 64'd0);
    chk("t4_halt_we", 64'(WB_o_gpr_we), 64'd1);
    chk("t4_halt_wdata", 64'(WB_o_gpr_wdata), 64'h77);
    step();
    drive(32'h30C, 32'h99, 5'd4, 1'b0); #1;
    chk("t4_drain_stall", 64'(FORWARD_stallWB), 64'd1);
    chk("t4_drain_we", 64'(WB_o_gpr_we), 64'd0);
    chk("t4_halted_d1", 64'(WB_o_halted), 64'd0);
    WB_o_commit_ready = 1'b1;
    step();
    chk("t4_halted_d2", 64'(WB_o_halted), 64'd0);
    step();
    chk("t4_halted_d3", 64'(WB_o_halted), 64'd0);
    chk("t4_last_head", 64'(WB_o_commit_pc), 64'h308);
    step();
    chk("t4_halted", 64'(WB_o_halted), 64'd1);
    chk("t4_empty", 64'(WB_o_commit_valid), 64'd0);
    chk("t4_halted_stall", 64'(FORWARD_stallWB), 64'd1);
    chk("t4_halted_we", 64'(WB_o_gpr_we), 64'd0);
    step();
    chk("t4_still_halted", 64'(WB_o_halted), 64'd1);
    chk("t4_cnt", WB_o_retire_cnt, 64'd14);

    // Reset out of HALTED, fill the FIFO ending with a halt, reset mid-drain.
    idle();
    rst = 1'b0; #1;
    chk("t5_rst_halted", 64'(WB_o_halted), 64'd0);
    exp_q.delete();
    step();
    rst = 1'b1;
    WB_o_commit_ready = 1'b0;
    drive(32'h400, 32'h1, 5'd6, 1'b0); step();
    drive(32'h404, 32'h2, 5'd6, 1'b0); step();
    drive(32'h408, 32'h3, 5'd6, 1'b0); step();
    drive(32'h40C, 32'h4, 5'd6, 1'b1); step();
    drive(32'h410, 32'h5, 5'd6, 1'b0); #1;
    chk("t5_drain_stall", 64'(FORWARD_stallWB), 64'd1);
    chk("t5_full_valid", 64'(WB_o_commit_valid), 64'd1);
    chk("t5_cnt_before", WB_o_retire_cnt, 64'd4);
    #2;
    rst = 1'b0; #1;
    chk("t5_rst_valid", 64'(WB_o_commit_valid), 64'd0);
    chk("t5_rst_halted2", 64'(WB_o_halted), 64'd0);
    chk("t5_rst_cnt", WB_o_retire_cnt, 64'd0);
    chk("t5_rst_stall", 64'(FORWARD_stallWB), 64'd0);
    idle();
    step();
    rst = 1'b1;
    WB_o_commit_ready = 1'b1;
    drive(32'h500, 32'h42, 5'd9, 1'b0); exp_q.push_back(32'h500); #1;
    chk("t5_we", 64'(WB_o_gpr_we), 64'd1);
    chk("t5_wdata", 64'(WB_o_gpr_wdata), 64'h42);
    chk("t5_stall", 64'(FORWARD_stallWB), 64'd0);
    step();
    idle(); #1;
    chk("t5_valid", 64'(WB_o_commit_valid), 64'd1);
    chk("t5_pc", 64'(WB_o_commit_pc), 64'h500);
    chk("t5_cnt", WB_o_retire_cnt, 64'd1);
    step(); #1;
    chk("t5_empty", 64'(WB_o_commit_valid), 64'd0);
    chk("t5_stream_done", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
